shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 130 +++++++++++++
 tb/tb_shift_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit barrel shift, one binary-weighted stage per clock.
// Optional SHSEQ_SKIP_EN: visit only the set bits of the shift amount.
module shift_sequencer #(
  parameter int DATA_W = 32,
  parameter int AMT_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              SH_DIR,
  input  logic [AMT_W-1:0]  SH_AMT,
  input  logic [DATA_W-1:0] D_IN,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] D_OUT
);

  localparam int CNT_W = (AMT_W > 1) ? $clog2(AMT_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [DATA_W-1:0]  acc, acc_n;
  logic               dir_r, dir_n;
  logic [AMT_W-1:0]   amt_r, amt_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]  dout_r, dout_n;

  logic [CNT_W-1:0]   sel;
  logic [AMT_W-1:0]   step;
  logic [DATA_W-1:0]  shifted;
  logic [DATA_W-1:0]  stage_val;
  logic               last;

`ifdef SHSEQ_SKIP_EN
  // Stage to apply this cycle: lowest bit still set in the amount.
  always_comb begin
    sel = '0;
    for (int i = AMT_W - 1; i >= 0; i--) begin
      if (amt_r[i]) sel = CNT_W'(i);
    end
  end
`else
  // Stage to apply this cycle: walk the stages in order.
  always_comb begin
    sel = cnt;
  end
`endif

  // One shift stage of weight 2^sel, arithmetic right or logical left.
  always_comb begin
    step = AMT_W'(1) << sel;
    if (dir_r)
      shifted = $unsigned($signed(acc) >>> step);
    else
      shifted = acc << step;
    stage_val = amt_r[sel] ? shifted : acc;
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      acc    <= '0;
      dir_r  <= 1'b0;
      amt_r  <= '0;
      cnt    <= '0;
      dout_r <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      dir_r  <= dir_n;
      amt_r  <= amt_n;
      cnt    <= cnt_n;
      dout_r <= dout_n;
    end
  end

  // Next-state and datapath update; result latched only on SHIFT->DONE.
  always_comb begin
    state_n = state;
    acc_n   = acc;
    dir_n   = dir_r;
    amt_n   = amt_r;
    cnt_n   = cnt;
    dout_n  = dout_r;
    last    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          acc_n   = D_IN;
          dir_n   = SH_DIR;
          amt_n   = SH_AMT;
          cnt_n   = '0;
          state_n = S_SHIFT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_SHIFT: begin
        acc_n = stage_val;
`ifdef SHSEQ_SKIP_EN
        amt_n = amt_r & (amt_r - AMT_W'(1));
        last  = (amt_n == '0);
`else
        last  = (cnt == CNT_W'(AMT_W - 1));
`endif
        if (last) begin
          dout_n  = stage_val;
          state_n = S_DONE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from the state.
  always_comb begin
    BUSY  = (state == S_SHIFT);
    DONE  = (state == S_DONE);
    D_OUT = dout_r;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed checks of shift_sequencer.
// Cycle expectations follow SHSEQ_SKIP_EN when defined.
module tb_shift_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        SH_DIR;
  logic [4:0]  SH_AMT;
  logic [31:0] D_IN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] D_OUT;

  int n_chk  = 0;
  int n_pass = 0;

  shift_sequencer #(.DATA_W(32), .AMT_W(5)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SH_DIR(SH_DIR),
    .SH_AMT(SH_AMT),
    .D_IN  (D_IN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .D_OUT (D_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int exp_cycles(input logic [4:0] amt);
`ifdef SHSEQ_SKIP_EN
    return (amt == 5'd0) ? 1 : $countones(amt);
`else
    return 5;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [31:0] din,
                        input logic dir, input logic [4:0] amt,
                        input logic [31:0] exp);
    int  busy_n;
    bit  seen;
    @(negedge CLK);
    START = 1'b1; D_IN = din; SH_DIR = dir; SH_AMT = amt;
    @(negedge CLK);
    START = 1'b0; D_IN = ~din; SH_DIR = ~dir; SH_AMT = ~amt;
    busy_n = 0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (DONE) begin
        seen = 1'b1;
        break;
      end
      if (BUSY) busy_n++;
      @(negedge CLK);
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_busy"}, 32'(busy_n), 32'(exp_cycles(amt)));
    chk({tag, "_dout"}, D_OUT, exp);
    @(negedge CLK);
    chk({tag, "_pulse"}, 32'(DONE), 32'd0);
    chk({tag, "_hold"}, D_OUT, exp);
  endtask

  initial begin
    int t1, t2, ndone;
    bit got_done;
    RST = 1'b1; START = 1'b0; SH_DIR = 1'b0;
    SH_AMT = '0; D_IN = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_dout", D_OUT, 32'd0);
    RST = 1'b0;

    run_op("sra5", 32'h8000_0010, 1'b1, 5'd5, 32'hFC00_0000);
    run_op("sll4", 32'h1234_5678, 1'b0, 5'd4, 32'h2345_6780);
    run_op("sll31", 32'h0000_0001, 1'b0, 5'd31, 32'h8000_0000);
    run_op("sra31n", 32'h8000_0000, 1'b1, 5'd31, 32'hFFFF_FFFF);
    run_op("sra31p", 32'h7FFF_FFFF, 1'b1, 5'd31, 32'h0000_0000);
    run_op("amt0", 32'hA5A5_1234, 1'b1, 5'd0, 32'hA5A5_1234);
    run_op("sra10", 32'hF000_0F00, 1'b1, 5'd10, 32'hFFFC_0003);

    // Back-to-back: START held, operand changed while busy.
    @(negedge CLK);
    START = 1'b1; D_IN = 32'h8000_0000; SH_DIR = 1'b1; SH_AMT = 5'd31;
    t1 = -1; t2 = -1; ndone = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (i == 1) D_IN = 32'h7FFF_FFFF;
      if (DONE) begin
        ndone++;
        if (ndone == 1) begin
          t1 = i;
          chk("b2b_first", D_OUT, 32'hFFFF_FFFF);
        end else begin
          t2 = i;
          chk("b2b_second", D_OUT, 32'h0000_0000);
          break;
        end
      end
      if (t1 > 0 && i == t1 + 1) begin
        chk("b2b_relaunch", 32'(BUSY), 32'd1);
        D_IN = 32'h1234_5678; SH_DIR = 1'b0; START = 1'b0;
      end
    end
    chk("b2b_count", 32'(ndone), 32'd2);
    chk("b2b_gap", 32'(t2 - t1), 32'd6);
    START = 1'b0;
    @(negedge CLK);

    // Reset in the 3rd SHIFT cycle aborts the operation.
    @(negedge CLK);
    START = 1'b1; D_IN = 32'h8000_0010; SH_DIR = 1'b1; SH_AMT = 5'd31;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort_busy_pre", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    chk("abort_dout", D_OUT, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (DONE || BUSY) got_done = 1'b1;
    end
    chk("abort_quiet", 32'(got_done), 32'd0);
    run_op("post_rst", 32'h0000_00FF, 1'b0, 5'd8, 32'h0000_FF00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
